mem_stage_lsu: RTL and testbench

- Load/store initiator for the pipelined processor's MEM stage; the requester side of the data-memory interface (address, write data, read/write controls out; read data back).
- Accepts one memory operation at a time from the EX/MEM latch, sequences the data-memory controls, stalls the pipeline while busy, and presents the writeback result to the MEM/WB latch.
- Non-memory instructions pass their ALU result straight through to writeback.

---
 rtl/mem_stage_lsu.sv | 125 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator: sequences data-memory reads/writes, stalls, writes back.
// Optional LSU_STORE_FWD_EN: one-entry store buffer forwards data to matching loads.
module mem_stage_lsu #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              CLOCK,
    input  logic              in_rst_n,
    input  logic              in_ex_valid,
    input  logic [ADDR_W-1:0] in_ex_alu_result,
    input  logic [DATA_W-1:0] in_ex_store_data,
    input  logic [REG_W-1:0]  in_ex_dest_reg,
    input  logic              cntrl_ex_mem_read,
    input  logic              cntrl_ex_mem_write,
    output logic              out_stall,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_data,
    output logic              cntrl_mem_read,
    output logic              cntrl_mem_write,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_wb_valid,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_W-1:0]  out_wb_dest
);

    typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

    localparam logic [3:0] LAT = 4'(MEM_RD_LAT);

    state_t           state;
    logic [3:0]       cnt;
    logic [REG_W-1:0] dest_q;
    logic             fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign out_stall = (state != IDLE);

`ifdef LSU_STORE_FWD_EN
    logic              buf_v;
    logic [ADDR_W-1:0] buf_a;
    logic [DATA_W-1:0] buf_d;

    assign fwd_hit  = buf_v && (buf_a == in_ex_alu_result);
    assign fwd_data = buf_d;

    // Buffer tracks the most recent store; only reset clears it
    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            buf_v <= 1'b0;
            buf_a <= '0;
            buf_d <= '0;
        end else if (state == IDLE && in_ex_valid && cntrl_ex_mem_write) begin
            buf_v <= 1'b1;
            buf_a <= in_ex_alu_result;
            buf_d <= in_ex_store_data;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            dest_q          <= '0;
            out_mem_addr    <= '0;
            out_mem_data    <= '0;
            cntrl_mem_read  <= 1'b0;
            cntrl_mem_write <= 1'b0;
            out_wb_valid    <= 1'b0;
            out_wb_data     <= '0;
            out_wb_dest     <= '0;
        end else begin
            out_wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_ex_valid) begin
                        dest_q <= in_ex_dest_reg;
                        if (cntrl_ex_mem_write) begin
                            state           <= WR;
                            cntrl_mem_write <= 1'b1;
                            out_mem_addr    <= in_ex_alu_result;
                            out_mem_data    <= in_ex_store_data;
                        end else if (cntrl_ex_mem_read && fwd_hit) begin
                            state       <= WB;
                            out_wb_data <= fwd_data;
                        end else if (cntrl_ex_mem_read) begin
                            state          <= RD;
                            cnt            <= LAT;
                            cntrl_mem_read <= 1'b1;
                            out_mem_addr   <= in_ex_alu_result;
                        end else begin
                            state       <= WB;
                            out_wb_data <= DATA_W'(in_ex_alu_result);
                        end
                    end
                end
                RD: begin
                    cnt <= cnt - 4'd1;
                    // Counter hits zero on this edge: sample the returned word
                    if (cnt == 4'd1) begin
                        state          <= WB;
                        cntrl_mem_read <= 1'b0;
                        out_wb_data    <= in_mem_data;
                    end
                end
                WR: begin
                    state           <= IDLE;
                    cntrl_mem_write <= 1'b0;
                end
                WB: begin
                    state        <= IDLE;
                    out_wb_valid <= 1'b1;
                    out_wb_dest  <= dest_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: two instances (read latency 1 and 3) share stimulus.
// Define LSU_STORE_FWD_EN to match an RTL build with store forwarding.
module tb_mem_stage_lsu;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = 4;
    localparam int K_WR = 1;
    localparam int K_RD = 2;
    localparam int K_WB = 3;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  r;
        int          cyc;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n;
    logic          ex_valid;
    logic [AW-1:0] ex_alu;
    logic [DW-1:0] ex_sd;
    logic [RW-1:0] ex_dest;
    logic          ex_rd;
    logic          ex_wr;

    logic          stall [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mdat  [2];
    logic          mrd   [2];
    logic          mwr   [2];
    logic [DW-1:0] mdin  [2];
    logic          wbv   [2];
    logic [DW-1:0] wbd   [2];
    logic [RW-1:0] wbr   [2];

    exp_t q [2][$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    bit          sb_v = 1'b0;
    logic [15:0] sb_a = '0;
    logic [15:0] sb_d = '0;

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] memfn(input logic [15:0] a);
        if (a == 16'h0004) return 16'h03F8;
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (cyc %0d)",
                     nm, g, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gdut
        assign mdin[g] = memfn(maddr[g]);
        mem_stage_lsu #(
            .DATA_W(DW), .ADDR_W(AW), .REG_W(RW),
            .MEM_RD_LAT((g == 0) ? 1 : 3)
        ) dut (
            .CLOCK(clk),
            .in_rst_n(rst_n),
            .in_ex_valid(ex_valid),
            .in_ex_alu_result(ex_alu),
            .in_ex_store_data(ex_sd),
            .in_ex_dest_reg(ex_dest),
            .cntrl_ex_mem_read(ex_rd),
            .cntrl_ex_mem_write(ex_wr),
            .out_stall(stall[g]),
            .out_mem_addr(maddr[g]),
            .out_mem_data(mdat[g]),
            .cntrl_mem_read(mrd[g]),
            .cntrl_mem_write(mwr[g]),
            .in_mem_data(mdin[g]),
            .out_wb_valid(wbv[g]),
            .out_wb_data(wbd[g]),
            .out_wb_dest(wbr[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : gmon
        int          run;
        logic [15:0] run_a;
        logic        prev_rd;
        exp_t        e;
        always @(negedge clk) begin
            if (!mon_en) begin
                run     = 0;
                prev_rd = 1'b0;
            end else begin
                chk("rd_wr_overlap", g, 32'(mrd[g] & mwr[g]), 32'd0);
                if (mwr[g]) begin
                    if (q[g].size() == 0) begin
                        chk("unexpected_write", g, 32'd1, 32'd0);
                    end else begin
                        e = q[g].pop_front();
                        chk("wr_kind", g, 32'(e.kind), 32'(K_WR));
                        chk("wr_addr", g, 32'(maddr[g]), 32'(e.a));
                        chk("wr_data", g, 32'(mdat[g]), 32'(e.d));
                        chk("wr_cycle", g, 32'(cyc), 32'(e.cyc));
                    end
                end
                if (mrd[g] && !prev_rd) begin
                    run   = 1;
                    run_a = maddr[g];
                end else if (mrd[g]) begin
                    run++;
                    chk("rd_addr_hold", g, 32'(maddr[g]), 32'(run_a));
                end else if (prev_rd) begin
                    if (q[g].size() == 0) begin
                        chk("unexpected_read", g, 32'd1, 32'd0);
                    end else begin
                        e = q[g].pop_front();
                        chk("rd_kind", g, 32'(e.kind), 32'(K_RD));
                        chk("rd_addr", g, 32'(run_a), 32'(e.a));
                        chk("rd_len", g, 32'(run), 32'(e.len));
                        chk("rd_end_cycle", g, 32'(cyc), 32'(e.cyc));
                    end
                end
                prev_rd = mrd[g];
                if (wbv[g]) begin
                    if (q[g].size() == 0) begin
                        chk("unexpected_wb", g, 32'd1, 32'd0);
                    end else begin
                        e = q[g].pop_front();
                        chk("wb_kind", g, 32'(e.kind), 32'(K_WB));
                        chk("wb_data", g, 32'(wbd[g]), 32'(e.d));
                        chk("wb_dest", g, 32'(wbr[g]), 32'(e.r));
                        chk("wb_cycle", g, 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((stall[0] || stall[1]) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("stall_timeout", 0, 32'd1, 32'd0);
    endtask

    task automatic push_exp(input bit wr, input bit rd, input logic [15:0] a,
                            input logic [15:0] d, input logic [3:0] r, input int acc);
        bit hit;
`ifdef LSU_STORE_FWD_EN
        hit = sb_v && (sb_a == a);
`else
        hit = 1'b0;
`endif
        for (int g = 0; g < 2; g++) begin
            if (wr) begin
                q[g].push_back('{K_WR, a, d, 4'd0, acc, 0});
            end else if (rd && hit) begin
                q[g].push_back('{K_WB, 16'd0, sb_d, r, acc + 1, 0});
            end else if (rd) begin
                q[g].push_back('{K_RD, a, 16'd0, 4'd0, acc + lat(g), lat(g)});
                q[g].push_back('{K_WB, 16'd0, memfn(a), r, acc + lat(g) + 1, 0});
            end else begin
                q[g].push_back('{K_WB, 16'd0, a, r, acc + 1, 0});
            end
        end
        if (wr) begin
            sb_v = 1'b1;
            sb_a = a;
            sb_d = d;
        end
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [15:0] d, input logic [3:0] r, input bit junk);
        wait_idle();
        ex_valid = 1'b1;
        ex_wr    = wr;
        ex_rd    = rd;
        ex_alu   = a;
        ex_sd    = d;
        ex_dest  = r;
        push_exp(wr, rd, a, d, r, cyc + 1);
        @(negedge clk);
        chk("stall_after_accept", 0, 32'(stall[0]), 32'd1);
        chk("stall_after_accept", 1, 32'(stall[1]), 32'd1);
        if (junk) begin
            ex_alu  = 16'($urandom);
            ex_sd   = 16'($urandom);
            ex_dest = 4'($urandom);
            ex_wr   = 1'($urandom);
            ex_rd   = 1'($urandom);
            @(negedge clk);
        end
        ex_valid = 1'b0;
        ex_wr    = 1'b0;
        ex_rd    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        ex_alu   = '0;
        ex_sd    = '0;
        ex_dest  = '0;
        ex_rd    = 1'b0;
        ex_wr    = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_stall", g, 32'(stall[g]), 32'd0);
            chk("rst_addr", g, 32'(maddr[g]), 32'd0);
            chk("rst_mdata", g, 32'(mdat[g]), 32'd0);
            chk("rst_rd", g, 32'(mrd[g]), 32'd0);
            chk("rst_wr", g, 32'(mwr[g]), 32'd0);
            chk("rst_wbv", g, 32'(wbv[g]), 32'd0);
            chk("rst_wbd", g, 32'(wbd[g]), 32'd0);
            chk("rst_wbr", g, 32'(wbr[g]), 32'd0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        issue(1'b1, 1'b0, 16'h019A, 16'h0004, 4'd3, 1'b0);
        issue(1'b0, 1'b1, 16'h0004, 16'h0000, 4'd7, 1'b0);
        issue(1'b0, 1'b0, 16'h1234, 16'h0000, 4'd5, 1'b0);
        issue(1'b1, 1'b1, 16'h0100, 16'hBEEF, 4'd9, 1'b0);
        issue(1'b0, 1'b1, 16'h0200, 16'h0000, 4'd2, 1'b1);
        issue(1'b1, 1'b0, 16'h0010, 16'h00AA, 4'd1, 1'b0);
        issue(1'b0, 1'b1, 16'h0010, 16'h0000, 4'd6, 1'b0);
        issue(1'b0, 1'b1, 16'h0011, 16'h0000, 4'd8, 1'b1);

        for (int i = 0; i < 200; i++) begin
            int          k;
            logic [15:0] a;
            k = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) a = 16'h0010 + 16'($urandom_range(0, 3));
            else a = 16'($urandom);
            issue(k == 1 || k == 3, k == 2 || k == 3, a, 16'($urandom),
                  4'($urandom), $urandom_range(0, 3) == 0);
        end

        wait_idle();
        repeat (6) @(negedge clk);
        chk("queue_drained", 0, 32'(q[0].size()), 32'd0);
        chk("queue_drained", 1, 32'(q[1].size()), 32'd0);

        mon_en   = 1'b0;
        ex_valid = 1'b1;
        ex_wr    = 1'b1;
        ex_alu   = 16'h0777;
        ex_sd    = 16'h1111;
        @(negedge clk);
        ex_valid = 1'b0;
        ex_wr    = 1'b0;
        chk("wr_before_rst", 0, 32'(mwr[0]), 32'd1);
        chk("wr_before_rst", 1, 32'(mwr[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wr_async_drop", 0, 32'(mwr[0]), 32'd0);
        chk("wr_async_drop", 1, 32'(mwr[1]), 32'd0);
        chk("stall_async_drop", 0, 32'(stall[0]), 32'd0);
        chk("stall_async_drop", 1, 32'(stall[1]), 32'd0);
        chk("addr_async_clear", 0, 32'(maddr[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
